// File: rtl/icache_pkg.sv
// Shared constants for the instruction cache: data width, boolean literals
// and the 2-bit controller state encoding.
package icache_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [DATA_WIDTH-1:0] ZERO_DATA = '0;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MISS_REQ  = 2'd1,
    ST_MISS_WAIT = 2'd2,
    ST_DRAIN     = 2'd3
  } icache_state_e;

  // Instruction fetches are word granular; the two byte-offset bits are dropped.
  function automatic logic [DATA_WIDTH-1:0] word_align(input logic [DATA_WIDTH-1:0] addr);
    return {addr[DATA_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/icache_store.sv
// Line storage for the direct-mapped instruction cache: one valid bit, one
// tag and one 32-bit word per line. Reads are combinational, writes land on
// the clock edge, so a lookup in the same cycle as a fill sees old contents.
// Only the valid bits are reset; tag and data need no reset because a line
// is never consulted while its valid bit is clear.
module icache_store
  import icache_pkg::*;
#(
  parameter int INDEX_WIDTH = 6,
  parameter int TAG_WIDTH   = DATA_WIDTH - INDEX_WIDTH - 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INDEX_WIDTH-1:0] rd_index_i,
  output logic                   rd_valid_o,
  output logic [TAG_WIDTH-1:0]   rd_tag_o,
  output logic [DATA_WIDTH-1:0]  rd_data_o,
  input  logic                   wr_en_i,
  input  logic [INDEX_WIDTH-1:0] wr_index_i,
  input  logic [TAG_WIDTH-1:0]   wr_tag_i,
  input  logic [DATA_WIDTH-1:0]  wr_data_i
);

  localparam int LINES = 1 << INDEX_WIDTH;

  logic [LINES-1:0]      valid_q;
  logic [TAG_WIDTH-1:0]  tag_q  [LINES];
  logic [DATA_WIDTH-1:0] data_q [LINES];

  // Valid bits: cleared on reset, set by a fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_index_i] <= TRUE;
    end
  end

  // Tag and data payload written on a fill.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_index_i]  <= wr_tag_i;
      data_q[wr_index_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_data_o  = data_q[rd_index_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache between fetch and the
// byte-serial memory controller. Hits answer one cycle after the request;
// misses issue a single word read and forward the returned word to fetch.
// A squash (in_clear) never cancels a read already sent to memory: the
// returning word still fills the line, it is just not forwarded.
// Optional build macro ICACHE_PERF_EN adds hit/miss counters.
//
// state        | meaning
// ST_IDLE      | lookup of the presented fetch address; hits answered here
// ST_MISS_REQ  | miss latched, waiting for memory to go idle to send the read
// ST_MISS_WAIT | read outstanding; the returning word fills and is forwarded
// ST_DRAIN     | read outstanding after a squash; fill only, no forward
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_clear,
  input  logic                  in_fetch_ena,
  input  logic [DATA_WIDTH-1:0] in_fetch_addr,
  output logic                  out_fetch_ok,
  output logic [DATA_WIDTH-1:0] out_fetch_inst,
  input  logic                  in_mem_busy,
  output logic                  out_mem_ena,
  output logic [DATA_WIDTH-1:0] out_mem_addr,
  input  logic                  in_mem_ok,
  input  logic [DATA_WIDTH-1:0] in_mem_data
`ifdef ICACHE_PERF_EN
  ,
  output logic [DATA_WIDTH-1:0] out_hit_cnt,
  output logic [DATA_WIDTH-1:0] out_miss_cnt
`endif
);

  localparam int TAG_WIDTH = DATA_WIDTH - INDEX_WIDTH - 2;

  icache_state_e         state_q, state_d;
  logic [DATA_WIDTH-1:0] miss_addr_q, miss_addr_d;
  logic                  fetch_ok_q, fetch_ok_d;
  logic [DATA_WIDTH-1:0] fetch_inst_q, fetch_inst_d;
  logic                  mem_ena_q, mem_ena_d;
  logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;

  logic                  fill_en;
  logic                  hit_ok;
  logic                  miss_enter;

  logic                  rd_valid;
  logic [TAG_WIDTH-1:0]  rd_tag;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  lookup_hit;

  icache_store #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .TAG_WIDTH   (TAG_WIDTH)
  ) u_store (
    .clk        (clk),
    .rst        (rst),
    .rd_index_i (in_fetch_addr[INDEX_WIDTH+1:2]),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .wr_en_i    (fill_en),
    .wr_index_i (miss_addr_q[INDEX_WIDTH+1:2]),
    .wr_tag_i   (miss_addr_q[DATA_WIDTH-1:INDEX_WIDTH+2]),
    .wr_data_i  (in_mem_data)
  );

  assign lookup_hit = rd_valid && (rd_tag == in_fetch_addr[DATA_WIDTH-1:INDEX_WIDTH+2]);

  // Controller state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      miss_addr_q  <= ZERO_DATA;
      fetch_ok_q   <= FALSE;
      fetch_inst_q <= ZERO_DATA;
      mem_ena_q    <= FALSE;
      mem_addr_q   <= ZERO_DATA;
    end else begin
      state_q      <= state_d;
      miss_addr_q  <= miss_addr_d;
      fetch_ok_q   <= fetch_ok_d;
      fetch_inst_q <= fetch_inst_d;
      mem_ena_q    <= mem_ena_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  // Next state, fill strobe and next output values; pulses default low.
  always_comb begin
    state_d      = state_q;
    miss_addr_d  = miss_addr_q;
    fetch_ok_d   = FALSE;
    fetch_inst_d = ZERO_DATA;
    mem_ena_d    = FALSE;
    mem_addr_d   = mem_addr_q;
    fill_en      = FALSE;
    hit_ok       = FALSE;
    miss_enter   = FALSE;
    case (state_q)
      ST_IDLE: begin
        if (in_fetch_ena && !in_clear) begin
          if (lookup_hit) begin
            fetch_ok_d   = TRUE;
            fetch_inst_d = rd_data;
            hit_ok       = TRUE;
          end else begin
            miss_addr_d = word_align(in_fetch_addr);
            miss_enter  = TRUE;
            state_d     = ST_MISS_REQ;
          end
        end
      end
      ST_MISS_REQ: begin
        if (in_clear) begin
          state_d = ST_IDLE;
        end else if (!in_mem_busy) begin
          mem_ena_d  = TRUE;
          mem_addr_d = miss_addr_q;
          state_d    = ST_MISS_WAIT;
        end
      end
      ST_MISS_WAIT: begin
        if (in_mem_ok) begin
          fill_en = TRUE;
          if (!in_clear) begin
            fetch_ok_d   = TRUE;
            fetch_inst_d = in_mem_data;
          end
          state_d = ST_IDLE;
        end else if (in_clear) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (in_mem_ok) begin
          fill_en = TRUE;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign out_fetch_ok   = fetch_ok_q;
  assign out_fetch_inst = fetch_inst_q;
  assign out_mem_ena    = mem_ena_q;
  assign out_mem_addr   = mem_addr_q;

`ifdef ICACHE_PERF_EN
  logic [DATA_WIDTH-1:0] hit_cnt_q, miss_cnt_q;

  // Hits counted when answered; misses counted on entry to the request
  // state, so squashed misses are included. Both wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= ZERO_DATA;
      miss_cnt_q <= ZERO_DATA;
    end else begin
      if (hit_ok)     hit_cnt_q  <= hit_cnt_q + 1'b1;
      if (miss_enter) miss_cnt_q <= miss_cnt_q + 1'b1;
    end
  end

  assign out_hit_cnt  = hit_cnt_q;
  assign out_miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache.sv
// Testbench for icache: directed scenarios plus randomized fetch traffic.
// Expected instructions and memory requests are queued when stimulus is
// issued and popped by an independent monitor. The reference model tracks
// which word address each line holds; memory contents are a fixed function
// of the word address.
module tb_icache;

  localparam int IW    = 6;
  localparam int LINES = 1 << IW;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_clear;
  logic        in_fetch_ena;
  logic [31:0] in_fetch_addr;
  logic        out_fetch_ok;
  logic [31:0] out_fetch_inst;
  logic        in_mem_busy;
  logic        out_mem_ena;
  logic [31:0] out_mem_addr;
  logic        in_mem_ok;
  logic [31:0] in_mem_data;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  icache #(.INDEX_WIDTH(IW)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_clear       (in_clear),
    .in_fetch_ena   (in_fetch_ena),
    .in_fetch_addr  (in_fetch_addr),
    .out_fetch_ok   (out_fetch_ok),
    .out_fetch_inst (out_fetch_inst),
    .in_mem_busy    (in_mem_busy),
    .out_mem_ena    (out_mem_ena),
    .out_mem_addr   (out_mem_addr),
    .in_mem_ok      (in_mem_ok),
    .in_mem_data    (in_mem_data)
`ifdef ICACHE_PERF_EN
    ,
    .out_hit_cnt    (hit_cnt),
    .out_miss_cnt   (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  bit          m_valid [LINES];
  logic [31:0] m_line  [LINES];
  int          m_hits   = 0;
  int          m_misses = 0;

  logic [31:0] exp_inst_q[$];
  logic [31:0] exp_mem_q[$];

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % LINES);
  endfunction

  function automatic logic [31:0] align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  function automatic logic [31:0] memword(input logic [31:0] wa);
    if (wa == 32'h0000_1000) return 32'h0051_3093;
    return (wa * 32'h9E37_79B1) ^ 32'h5EED_0000;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return m_valid[idx_of(a)] && (m_line[idx_of(a)] == align(a));
  endfunction

  task automatic model_fill(input logic [31:0] a);
    m_valid[idx_of(a)] = 1'b1;
    m_line[idx_of(a)]  = align(a);
  endtask

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  // ---------------- memory controller model ----------------
  logic        force_busy = 1'b0;
  bit          pending = 1'b0;
  int          lat = 0;
  logic [31:0] req_addr = '0;
  int          mem_req_cnt = 0;

  initial begin
    in_mem_ok   = 1'b0;
    in_mem_data = '0;
    in_mem_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      in_mem_ok   = 1'b0;
      in_mem_data = '0;
      if (rst) begin
        pending = 1'b0;
      end else begin
        if (pending) begin
          if (lat == 0) begin
            in_mem_ok   = 1'b1;
            in_mem_data = memword(req_addr);
            pending     = 1'b0;
          end else begin
            lat--;
          end
        end
        if (out_mem_ena) begin
          mem_req_cnt++;
          check("mem_request_overlap", {31'd0, pending}, 32'd0);
          pending  = 1'b1;
          lat      = 4;
          req_addr = out_mem_addr;
        end
      end
      in_mem_busy = pending | force_busy;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (out_fetch_ok) begin
      if (exp_inst_q.size() == 0) check("fetch_ok_unexpected", {31'd0, out_fetch_ok}, 32'd0);
      else check("fetch_inst", out_fetch_inst, exp_inst_q.pop_front());
    end else begin
      check("fetch_inst_zero_when_no_ok", out_fetch_inst, 32'd0);
    end
    if (out_mem_ena) begin
      if (exp_mem_q.size() == 0) check("mem_ena_unexpected", {31'd0, out_mem_ena}, 32'd0);
      else check("mem_addr", out_mem_addr, exp_mem_q.pop_front());
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic check_perf();
`ifdef ICACHE_PERF_EN
    check("perf_hit_cnt", hit_cnt, m_hits);
    check("perf_miss_cnt", miss_cnt, m_misses);
`endif
  endtask

  task automatic do_fetch(input logic [31:0] a, input int busy_cycles);
    logic [31:0] wa;
    bit          hit;
    int          n;
    int          req0;
    wa   = align(a);
    hit  = model_hit(a);
    if (hit) busy_cycles = 0;
    exp_inst_q.push_back(memword(wa));
    if (!hit) exp_mem_q.push_back(wa);
    req0 = mem_req_cnt;
    if (busy_cycles > 0) force_busy = 1'b1;
    in_fetch_ena  = 1'b1;
    in_fetch_addr = a;
    n = 0;
    while (n < 200) begin
      cyc();
      n++;
      if (busy_cycles > 0 && n == busy_cycles) begin
        check("mem_ena_held_while_busy", mem_req_cnt - req0, 32'd0);
        force_busy = 1'b0;
      end
      if (out_fetch_ok) break;
    end
    force_busy   = 1'b0;
    in_fetch_ena = 1'b0;
    if (!out_fetch_ok) check("fetch_timeout", {31'd0, out_fetch_ok}, 32'd1);
    if (hit) check("hit_latency", n, 32'd1);
    else if (busy_cycles == 0) check("miss_latency", n, 32'd8);
    check("mem_req_per_fetch", mem_req_cnt - req0, hit ? 32'd0 : 32'd1);
    if (hit) m_hits++;
    else begin
      m_misses++;
      model_fill(a);
    end
  endtask

  // mode 0: clear with the request in IDLE; 1: clear while waiting on a busy
  // memory; 2: clear two cycles after the read is issued; 3: clear in the
  // same cycle the read data returns.
  task automatic do_squash(input logic [31:0] a, input int mode);
    int req0;
    int n;
    if (model_hit(a)) mode = 0;
    req0 = mem_req_cnt;
    case (mode)
      0: begin
        in_fetch_ena  = 1'b1;
        in_fetch_addr = a;
        in_clear      = 1'b1;
        cyc();
        in_clear     = 1'b0;
        in_fetch_ena = 1'b0;
        cyc();
        check("clear_idle_no_ok", {31'd0, out_fetch_ok}, 32'd0);
        cyc();
        check("clear_idle_no_req", mem_req_cnt - req0, 32'd0);
      end
      1: begin
        force_busy    = 1'b1;
        in_fetch_ena  = 1'b1;
        in_fetch_addr = a;
        repeat (3) cyc();
        in_clear     = 1'b1;
        in_fetch_ena = 1'b0;
        cyc();
        in_clear   = 1'b0;
        force_busy = 1'b0;
        repeat (4) cyc();
        check("clear_req_no_mem_ena", mem_req_cnt - req0, 32'd0);
        m_misses++;
      end
      2: begin
        exp_mem_q.push_back(align(a));
        in_fetch_ena  = 1'b1;
        in_fetch_addr = a;
        n = 0;
        while (mem_req_cnt == req0 && n < 30) begin cyc(); n++; end
        check("squash_wait_req_seen", mem_req_cnt - req0, 32'd1);
        repeat (2) cyc();
        in_clear     = 1'b1;
        in_fetch_ena = 1'b0;
        cyc();
        in_clear = 1'b0;
        n = 0;
        while (!in_mem_ok && n < 30) begin cyc(); n++; end
        check("drain_mem_ok_seen", {31'd0, in_mem_ok}, 32'd1);
        cyc();
        check("drain_no_ok", {31'd0, out_fetch_ok}, 32'd0);
        model_fill(a);
        m_misses++;
      end
      default: begin
        exp_mem_q.push_back(align(a));
        in_fetch_ena  = 1'b1;
        in_fetch_addr = a;
        n = 0;
        while (!in_mem_ok && n < 40) begin cyc(); n++; end
        check("clear_ok_mem_ok_seen", {31'd0, in_mem_ok}, 32'd1);
        in_clear = 1'b1;
        cyc();
        in_clear     = 1'b0;
        in_fetch_ena = 1'b0;
        check("clear_with_ok_no_ok", {31'd0, out_fetch_ok}, 32'd0);
        model_fill(a);
        m_misses++;
      end
    endcase
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_fetch_ok"},   {31'd0, out_fetch_ok}, 32'd0);
    check({tag, "_fetch_inst"}, out_fetch_inst, 32'd0);
    check({tag, "_mem_ena"},    {31'd0, out_mem_ena}, 32'd0);
    check({tag, "_mem_addr"},   out_mem_addr, 32'd0);
  endtask

  task automatic do_reset_mid_miss(input logic [31:0] a);
    int req0;
    int n;
    req0 = mem_req_cnt;
    exp_mem_q.push_back(align(a));
    in_fetch_ena  = 1'b1;
    in_fetch_addr = a;
    n = 0;
    while (mem_req_cnt == req0 && n < 30) begin cyc(); n++; end
    check("reset_mid_miss_req_seen", mem_req_cnt - req0, 32'd1);
    cyc();
    rst          = 1'b1;
    in_fetch_ena = 1'b0;
    cyc();
    exp_inst_q.delete();
    exp_mem_q.delete();
    model_reset();
    cyc();
    check_reset_outputs("mid_reset");
    rst = 1'b0;
    check_perf();
    repeat (8) cyc();
    check("reset_no_stale_ok", {31'd0, out_fetch_ok}, 32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    return 32'h0000_1000 + ($urandom_range(0, 3) << 8) + ($urandom_range(0, 7) << 2)
           + $urandom_range(0, 3);
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    rst           = 1'b1;
    in_clear      = 1'b0;
    in_fetch_ena  = 1'b0;
    in_fetch_addr = '0;
    model_reset();
    repeat (3) cyc();
    check_reset_outputs("reset");
    check_perf();
    rst = 1'b0;
    cyc();

    do_fetch(32'h0000_1000, 0);
    do_fetch(32'h0000_1000, 0);
    do_fetch(32'h0000_1100, 0);
    do_fetch(32'h0000_1000, 0);
    do_fetch(32'h0000_2040, 8);
    do_fetch(32'h0000_2040, 0);
    do_squash(32'h0000_3080, 2);
    do_fetch(32'h0000_3080, 0);
    do_squash(32'h0000_30C0, 3);
    do_fetch(32'h0000_30C0, 0);
    do_squash(32'h0000_3100, 1);
    do_fetch(32'h0000_3100, 0);
    do_squash(32'h0000_1000, 0);
    do_fetch(32'h0000_5003, 0);
    do_fetch(32'h0000_5001, 0);
    check_perf();

    for (int i = 0; i < 300; i++) begin
      int          r;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      a = rand_addr();
      if (r == 0) do_squash(a, $urandom_range(0, 3));
      else if (r == 1) do_fetch(a, $urandom_range(2, 6));
      else do_fetch(a, 0);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) cyc();
    end
    check_perf();

    do_fetch(32'h0000_1000, 0);
    do_reset_mid_miss(32'h0000_7FF0);
    do_fetch(32'h0000_1000, 0);
    check_perf();

    repeat (4) cyc();
    check("exp_inst_drained", exp_inst_q.size(), 32'd0);
    check("exp_mem_drained", exp_mem_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
